// File: rtl/upsp_sched_pkg.sv
// Shared types and sizing helpers for the upsampler write scheduler.
package upsp_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } sched_state_e;

    localparam int MIN_CNT_W = 1;

    function automatic int beats_per_row(input int dstWidth, input int pixPerBeat);
        return dstWidth / pixPerBeat;
    endfunction

    // A counter over n values never collapses below one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? MIN_CNT_W : $clog2(n);
    endfunction

endpackage

// File: rtl/upsp_sched_outreg.sv
// Single-stage valid/ready output register carrying {tuser, tlast, tdata}.
module upsp_sched_outreg #(
    parameter int WIDTH = 98
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             canAccept_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // Payload is held while valid and not accepted; a load replaces it on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o     = valid_q;
    assign data_o      = data_q;
    assign canAccept_o = !valid_q || ready_i;

endmodule

// File: rtl/upsp_wr_scheduler.sv
// Strict round-robin scheduler merging upsampler unit beats into one raster-ordered AXI-Stream.
module upsp_wr_scheduler
    import upsp_sched_pkg::*;
#(
    parameter int N_PARALLEL         = 4,
    parameter int UPSP_WRTDATA_WIDTH = 96,
    parameter int PIX_PER_BEAT       = 4,
    parameter int GRANT_BEATS        = 2,
    parameter int DST_IMG_WIDTH      = 3840,
    parameter int DST_IMG_HEIGHT     = 2160
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     crf_ac_UPSTART,
    output logic                                     sched_busy,
    output logic                                     sched_done,
    input  logic [N_PARALLEL-1:0]                    upsp_ac_wvalid,
    input  logic [N_PARALLEL*UPSP_WRTDATA_WIDTH-1:0] upsp_ac_wdata,
    output logic [N_PARALLEL-1:0]                    ac_upsp_wready,
    output logic                                     ac_m_axis_tvalid,
    output logic [UPSP_WRTDATA_WIDTH-1:0]            ac_m_axis_tdata,
    output logic                                     ac_m_axis_tlast,
    output logic                                     ac_m_axis_tuser,
    input  logic                                     ac_m_axis_tready,
    output logic [$clog2(N_PARALLEL)-1:0]            sched_grant
);

    localparam int W             = UPSP_WRTDATA_WIDTH;
    localparam int BEATS_PER_ROW = beats_per_row(DST_IMG_WIDTH, PIX_PER_BEAT);
    localparam int GRANT_W       = cnt_width(N_PARALLEL);
    localparam int BEAT_W        = cnt_width(GRANT_BEATS);
    localparam int COL_W         = cnt_width(BEATS_PER_ROW);
    localparam int ROW_W         = cnt_width(DST_IMG_HEIGHT);

    localparam logic [GRANT_W-1:0] GRANT_MAX = GRANT_W'(N_PARALLEL - 1);
    localparam logic [BEAT_W-1:0]  BEAT_MAX  = BEAT_W'(GRANT_BEATS - 1);
    localparam logic [COL_W-1:0]   COL_MAX   = COL_W'(BEATS_PER_ROW - 1);
    localparam logic [ROW_W-1:0]   ROW_MAX   = ROW_W'(DST_IMG_HEIGHT - 1);

    if (BEATS_PER_ROW % (N_PARALLEL * GRANT_BEATS) != 0) begin : g_illegal
        $error("BEATS_PER_ROW must be a multiple of N_PARALLEL*GRANT_BEATS");
    end

    sched_state_e       state_q, state_d;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic [BEAT_W-1:0]  beatCnt_q, beatCnt_d;
    logic [COL_W-1:0]   colCnt_q, colCnt_d;
    logic [ROW_W-1:0]   rowCnt_q, rowCnt_d;

    logic [W-1:0] unitData [N_PARALLEL];
    logic         canAccept;
    logic         canLoad;
    logic         transfer;
    logic         lastBeat;
    logic         rowStart;

    for (genvar i = 0; i < N_PARALLEL; i++) begin : g_slice
        assign unitData[i] = upsp_ac_wdata[i*W +: W];
    end

    assign canLoad  = (state_q == RUN) && canAccept;
    assign transfer = canLoad && upsp_ac_wvalid[grant_q];
    assign lastBeat = (colCnt_q == COL_MAX) && (rowCnt_q == ROW_MAX);
    assign rowStart = (colCnt_q == '0) && (rowCnt_q == '0);

    always_comb begin
        ac_upsp_wready          = '0;
        ac_upsp_wready[grant_q] = canLoad;
    end

    upsp_sched_outreg #(
        .WIDTH (W + 2)
    ) u_outreg (
        .clk         (clk),
        .rst         (rst),
        .load_i      (transfer),
        .data_i      ({rowStart, colCnt_q == COL_MAX, unitData[grant_q]}),
        .ready_i     (ac_m_axis_tready),
        .valid_o     (ac_m_axis_tvalid),
        .data_o      ({ac_m_axis_tuser, ac_m_axis_tlast, ac_m_axis_tdata}),
        .canAccept_o (canAccept)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            beatCnt_q <= '0;
            colCnt_q  <= '0;
            rowCnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            beatCnt_q <= beatCnt_d;
            colCnt_q  <= colCnt_d;
            rowCnt_q  <= rowCnt_d;
        end
    end

    // Counters only move on a unit transfer; the frame's last transfer rewinds them for the next frame.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        beatCnt_d  = beatCnt_q;
        colCnt_d   = colCnt_q;
        rowCnt_d   = rowCnt_q;
        sched_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (crf_ac_UPSTART) state_d = RUN;
            end
            RUN: begin
                if (transfer) begin
                    if (lastBeat) begin
                        state_d   = FLUSH;
                        grant_d   = '0;
                        beatCnt_d = '0;
                        colCnt_d  = '0;
                        rowCnt_d  = '0;
                    end else begin
                        if (beatCnt_q == BEAT_MAX) begin
                            beatCnt_d = '0;
                            grant_d   = (grant_q == GRANT_MAX) ? '0 : grant_q + 1'b1;
                        end else begin
                            beatCnt_d = beatCnt_q + 1'b1;
                        end
                        if (colCnt_q == COL_MAX) begin
                            colCnt_d = '0;
                            rowCnt_d = rowCnt_q + 1'b1;
                        end else begin
                            colCnt_d = colCnt_q + 1'b1;
                        end
                    end
                end
            end
            FLUSH: begin
                if (ac_m_axis_tvalid && ac_m_axis_tready) begin
                    state_d    = IDLE;
                    sched_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sched_busy  = (state_q != IDLE);
    assign sched_grant = grant_q;

endmodule

// File: tb/tb_upsp_wr_scheduler.sv
// Self-checking bench for upsp_wr_scheduler on a small 8x2 frame with two units.
module tb_upsp_wr_scheduler;

    localparam int N     = 2;
    localparam int W     = 16;
    localparam int G     = 2;
    localparam int DW    = 8;
    localparam int DH    = 2;
    localparam int BPR   = DW;
    localparam int FRAME = BPR * DH;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           crf_ac_UPSTART = 1'b0;
    logic           sched_busy;
    logic           sched_done;
    logic [N-1:0]   upsp_ac_wvalid = '0;
    logic [N*W-1:0] upsp_ac_wdata = '0;
    logic [N-1:0]   ac_upsp_wready;
    logic           ac_m_axis_tvalid;
    logic [W-1:0]   ac_m_axis_tdata;
    logic           ac_m_axis_tlast;
    logic           ac_m_axis_tuser;
    logic           ac_m_axis_tready = 1'b0;
    logic [0:0]     sched_grant;

    always #5 clk = ~clk;

    upsp_wr_scheduler #(
        .N_PARALLEL         (N),
        .UPSP_WRTDATA_WIDTH (W),
        .PIX_PER_BEAT       (1),
        .GRANT_BEATS        (G),
        .DST_IMG_WIDTH      (DW),
        .DST_IMG_HEIGHT     (DH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .crf_ac_UPSTART   (crf_ac_UPSTART),
        .sched_busy       (sched_busy),
        .sched_done       (sched_done),
        .upsp_ac_wvalid   (upsp_ac_wvalid),
        .upsp_ac_wdata    (upsp_ac_wdata),
        .ac_upsp_wready   (ac_upsp_wready),
        .ac_m_axis_tvalid (ac_m_axis_tvalid),
        .ac_m_axis_tdata  (ac_m_axis_tdata),
        .ac_m_axis_tlast  (ac_m_axis_tlast),
        .ac_m_axis_tuser  (ac_m_axis_tuser),
        .ac_m_axis_tready (ac_m_axis_tready),
        .sched_grant      (sched_grant)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  seq [N];
    logic [17:0] obsQ [$];
    int          obsCyc [$];
    int          cycNo = 0;
    int          doneCount;
    int          doneBeat;
    int          xferCnt;

    logic         sTvalid, sTlast, sTuser, sBusy, sDone;
    logic [W-1:0] sTdata;
    logic [N-1:0] sWready;
    logic [0:0]   sGrant;

    // Unit u's k-th beat overall is its (k/(G*N))*G + k%G-th beat; grant order is k/G mod N.
    function automatic logic [17:0] expBeat(input int k);
        int unit;
        int s;
        unit = (k / G) % N;
        s    = (k / (G * N)) * G + (k % G);
        return {(k == 0), ((k % BPR) == BPR - 1), 8'(unit), 8'(s)};
    endfunction

    task automatic new_frame();
        obsQ.delete();
        obsCyc.delete();
        for (int i = 0; i < N; i++) seq[i] = 8'd0;
        doneCount = 0;
        doneBeat  = -1;
        xferCnt   = 0;
    endtask

    // Drives one cycle of inputs and records what the next rising edge will commit.
    task automatic cycle(input logic [N-1:0] vld, input logic rdy, input logic st, input logic rs);
        @(negedge clk);
        rst              = rs;
        crf_ac_UPSTART   = st;
        upsp_ac_wvalid   = vld;
        ac_m_axis_tready = rdy;
        for (int i = 0; i < N; i++) upsp_ac_wdata[i*W +: W] = {8'(i), seq[i]};
        #1;
        sTvalid = ac_m_axis_tvalid;
        sTdata  = ac_m_axis_tdata;
        sTlast  = ac_m_axis_tlast;
        sTuser  = ac_m_axis_tuser;
        sWready = ac_upsp_wready;
        sBusy   = sched_busy;
        sDone   = sched_done;
        sGrant  = sched_grant;
        if (sTvalid && rdy) begin
            obsQ.push_back({sTuser, sTlast, sTdata});
            obsCyc.push_back(cycNo);
        end
        if (sDone) begin
            doneCount++;
            doneBeat = obsQ.size();
        end
        for (int i = 0; i < N; i++) begin
            if (vld[i] && sWready[i]) begin
                seq[i] = seq[i] + 8'd1;
                xferCnt++;
            end
        end
        cycNo++;
    endtask

    task automatic test_reset();
        repeat (3) cycle(2'b11, 1'b1, 1'b1, 1'b1);
        cycle(2'b00, 1'b0, 1'b0, 1'b0);
        total++; if (sTvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_tvalid got %b want 0", sTvalid); end
        total++; if (sTdata !== 16'h0) begin bad++; $display("[TB] FAIL reset_tdata got %h want 0000", sTdata); end
        total++; if (sTlast !== 1'b0) begin bad++; $display("[TB] FAIL reset_tlast got %b want 0", sTlast); end
        total++; if (sTuser !== 1'b0) begin bad++; $display("[TB] FAIL reset_tuser got %b want 0", sTuser); end
        total++; if (sWready !== 2'b00) begin bad++; $display("[TB] FAIL reset_wready got %b want 00", sWready); end
        total++; if (sBusy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy_start_ignored got %b want 0", sBusy); end
        total++; if (sDone !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got %b want 0", sDone); end
        total++; if (sGrant !== 1'b0) begin bad++; $display("[TB] FAIL reset_grant got %b want 0", sGrant); end
    endtask

    task automatic test_full_rate();
        int guard;
        int startCyc;
        new_frame();
        startCyc = cycNo;
        cycle(2'b11, 1'b1, 1'b1, 1'b0);
        guard = 0;
        while (doneCount == 0 && guard < 100) begin cycle(2'b11, 1'b1, 1'b0, 1'b0); guard++; end
        total++; if (doneCount == 0) begin bad++; $display("[TB] FAIL full_timeout got no done want done"); end
        cycle(2'b11, 1'b1, 1'b0, 1'b0);
        total++; if (sBusy !== 1'b0) begin bad++; $display("[TB] FAIL full_busy_after got %b want 0", sBusy); end
        total++; if (obsQ.size() != FRAME) begin bad++; $display("[TB] FAIL full_count got %0d want %0d", obsQ.size(), FRAME); end
        for (int k = 0; k < obsQ.size() && k < FRAME; k++) begin
            total++; if (obsQ[k] !== expBeat(k)) begin bad++; $display("[TB] FAIL full_beat%0d got %h want %h", k, obsQ[k], expBeat(k)); end
        end
        if (obsCyc.size() >= FRAME) begin
            total++; if (obsCyc[0] != startCyc + 2) begin bad++; $display("[TB] FAIL full_latency got cycle %0d want %0d", obsCyc[0], startCyc + 2); end
            total++; if (obsCyc[FRAME-1] - obsCyc[0] != FRAME - 1) begin bad++; $display("[TB] FAIL full_throughput got span %0d want %0d", obsCyc[FRAME-1] - obsCyc[0], FRAME - 1); end
        end
        total++; if (doneCount != 1) begin bad++; $display("[TB] FAIL full_done_count got %0d want 1", doneCount); end
        total++; if (doneBeat != FRAME) begin bad++; $display("[TB] FAIL full_done_beat got %0d want %0d", doneBeat, FRAME); end
    endtask

    task automatic test_unit_stall();
        int guard;
        int xferBefore;
        int u0Ready;
        new_frame();
        cycle(2'b11, 1'b1, 1'b1, 1'b0);
        guard = 0;
        while (xferCnt < 2 && guard < 50) begin cycle(2'b11, 1'b1, 1'b0, 1'b0); guard++; end
        xferBefore = xferCnt;
        u0Ready = 0;
        repeat (10) begin
            cycle(2'b01, 1'b1, 1'b0, 1'b0);
            if (sWready[0]) u0Ready++;
        end
        total++; if (xferCnt != xferBefore) begin bad++; $display("[TB] FAIL stall_xfer got %0d want %0d", xferCnt, xferBefore); end
        total++; if (u0Ready != 0) begin bad++; $display("[TB] FAIL stall_no_skip got %0d unit0 ready cycles want 0", u0Ready); end
        total++; if (obsQ.size() != 2) begin bad++; $display("[TB] FAIL stall_output got %0d beats want 2", obsQ.size()); end
        guard = 0;
        while (doneCount == 0 && guard < 100) begin cycle(2'b11, 1'b1, 1'b0, 1'b0); guard++; end
        total++; if (obsQ.size() != FRAME) begin bad++; $display("[TB] FAIL stall_count got %0d want %0d", obsQ.size(), FRAME); end
        for (int k = 0; k < obsQ.size() && k < FRAME; k++) begin
            total++; if (obsQ[k] !== expBeat(k)) begin bad++; $display("[TB] FAIL stall_beat%0d got %h want %h", k, obsQ[k], expBeat(k)); end
        end
        total++; if (doneCount != 1) begin bad++; $display("[TB] FAIL stall_done_count got %0d want 1", doneCount); end
    endtask

    task automatic test_tready_toggle();
        int guard;
        logic rdy;
        logic holdPending;
        logic [W-1:0] holdData;
        new_frame();
        cycle(2'b11, 1'b0, 1'b1, 1'b0);
        rdy = 1'b1;
        holdPending = 1'b0;
        holdData = '0;
        guard = 0;
        while (doneCount == 0 && guard < 200) begin
            cycle(2'b11, rdy, 1'b0, 1'b0);
            if (holdPending) begin
                total++;
                if (sTvalid !== 1'b1 || sTdata !== holdData) begin
                    bad++; $display("[TB] FAIL toggle_hold got v=%b d=%h want v=1 d=%h", sTvalid, sTdata, holdData);
                end
            end
            holdPending = sTvalid && !rdy;
            holdData = sTdata;
            rdy = ~rdy;
            guard++;
        end
        total++; if (obsQ.size() != FRAME) begin bad++; $display("[TB] FAIL toggle_count got %0d want %0d", obsQ.size(), FRAME); end
        for (int k = 0; k < obsQ.size() && k < FRAME; k++) begin
            total++; if (obsQ[k] !== expBeat(k)) begin bad++; $display("[TB] FAIL toggle_beat%0d got %h want %h", k, obsQ[k], expBeat(k)); end
        end
        total++; if (doneCount != 1 || doneBeat != FRAME) begin bad++; $display("[TB] FAIL toggle_done got count=%0d beat=%0d want 1/%0d", doneCount, doneBeat, FRAME); end
    endtask

    task automatic test_restart_ignored();
        int guard;
        logic restarted;
        new_frame();
        cycle(2'b11, 1'b1, 1'b1, 1'b0);
        restarted = 1'b0;
        guard = 0;
        while (doneCount == 0 && guard < 100) begin
            if (!restarted && obsQ.size() == 5) begin
                cycle(2'b11, 1'b1, 1'b1, 1'b0);
                restarted = 1'b1;
            end else begin
                cycle(2'b11, 1'b1, 1'b0, 1'b0);
            end
            guard++;
        end
        repeat (3) cycle(2'b11, 1'b1, 1'b0, 1'b0);
        total++; if (sBusy !== 1'b0) begin bad++; $display("[TB] FAIL restart_busy_after got %b want 0", sBusy); end
        total++; if (obsQ.size() != FRAME) begin bad++; $display("[TB] FAIL restart_count got %0d want %0d", obsQ.size(), FRAME); end
        for (int k = 0; k < obsQ.size() && k < FRAME; k++) begin
            total++; if (obsQ[k] !== expBeat(k)) begin bad++; $display("[TB] FAIL restart_beat%0d got %h want %h", k, obsQ[k], expBeat(k)); end
        end
        total++; if (doneCount != 1) begin bad++; $display("[TB] FAIL restart_done_count got %0d want 1", doneCount); end
    endtask

    task automatic test_reset_abort();
        int guard;
        new_frame();
        cycle(2'b11, 1'b1, 1'b1, 1'b0);
        guard = 0;
        while (obsQ.size() < 9 && guard < 100) begin cycle(2'b11, 1'b1, 1'b0, 1'b0); guard++; end
        cycle(2'b11, 1'b1, 1'b0, 1'b1);
        cycle(2'b00, 1'b1, 1'b0, 1'b0);
        total++; if (sTvalid !== 1'b0 || sTdata !== 16'h0 || sTlast !== 1'b0 || sTuser !== 1'b0) begin
            bad++; $display("[TB] FAIL abort_outputs got v=%b d=%h l=%b u=%b want all 0", sTvalid, sTdata, sTlast, sTuser);
        end
        total++; if (sBusy !== 1'b0 || sWready !== 2'b00 || sGrant !== 1'b0) begin
            bad++; $display("[TB] FAIL abort_state got busy=%b wready=%b grant=%b want 0/00/0", sBusy, sWready, sGrant);
        end
        total++; if (doneCount != 0) begin bad++; $display("[TB] FAIL abort_no_done got %0d want 0", doneCount); end
        new_frame();
        cycle(2'b11, 1'b1, 1'b1, 1'b0);
        guard = 0;
        while (doneCount == 0 && guard < 100) begin cycle(2'b11, 1'b1, 1'b0, 1'b0); guard++; end
        total++; if (obsQ.size() != FRAME) begin bad++; $display("[TB] FAIL abort_new_count got %0d want %0d", obsQ.size(), FRAME); end
        for (int k = 0; k < obsQ.size() && k < FRAME; k++) begin
            total++; if (obsQ[k] !== expBeat(k)) begin bad++; $display("[TB] FAIL abort_new_beat%0d got %h want %h", k, obsQ[k], expBeat(k)); end
        end
    endtask

    task automatic test_flush_stall();
        int guard;
        logic [17:0] eb;
        new_frame();
        cycle(2'b11, 1'b1, 1'b1, 1'b0);
        guard = 0;
        while (xferCnt < FRAME && guard < 100) begin cycle(2'b11, 1'b1, 1'b0, 1'b0); guard++; end
        eb = expBeat(FRAME - 1);
        repeat (5) begin
            cycle(2'b11, 1'b0, 1'b0, 1'b0);
            total++;
            if (sBusy !== 1'b1 || sDone !== 1'b0 || sTvalid !== 1'b1 || sTdata !== eb[15:0]) begin
                bad++; $display("[TB] FAIL flush_hold got busy=%b done=%b v=%b d=%h want 1/0/1/%h", sBusy, sDone, sTvalid, sTdata, eb[15:0]);
            end
        end
        cycle(2'b11, 1'b1, 1'b0, 1'b0);
        total++; if (sDone !== 1'b1) begin bad++; $display("[TB] FAIL flush_done got %b want 1", sDone); end
        cycle(2'b11, 1'b1, 1'b0, 1'b0);
        total++; if (sBusy !== 1'b0) begin bad++; $display("[TB] FAIL flush_busy_after got %b want 0", sBusy); end
        total++; if (obsQ.size() != FRAME) begin bad++; $display("[TB] FAIL flush_count got %0d want %0d", obsQ.size(), FRAME); end
        for (int k = 0; k < obsQ.size() && k < FRAME; k++) begin
            total++; if (obsQ[k] !== expBeat(k)) begin bad++; $display("[TB] FAIL flush_beat%0d got %h want %h", k, obsQ[k], expBeat(k)); end
        end
        total++; if (doneCount != 1) begin bad++; $display("[TB] FAIL flush_done_count got %0d want 1", doneCount); end
    endtask

    task automatic test_random();
        int guard;
        logic [N-1:0] vld;
        logic rdy;
        logic st;
        logic holdPending;
        logic [W-1:0] holdData;
        logic [N-1:0] others;
        for (int f = 0; f < 3; f++) begin
            new_frame();
            cycle(N'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            holdPending = 1'b0;
            holdData = '0;
            guard = 0;
            while (doneCount == 0 && guard < 2000) begin
                vld = N'($urandom_range(0, 3));
                rdy = ($urandom_range(0, 3) != 0);
                st  = ($urandom_range(0, 7) == 0);
                cycle(vld, rdy, st, 1'b0);
                others = sWready & ~(N'(1) << sGrant);
                total++; if (others !== '0) begin bad++; $display("[TB] FAIL rand_wready got %b with grant %0d", sWready, sGrant); end
                if (holdPending) begin
                    total++;
                    if (sTvalid !== 1'b1 || sTdata !== holdData) begin
                        bad++; $display("[TB] FAIL rand_hold got v=%b d=%h want v=1 d=%h", sTvalid, sTdata, holdData);
                    end
                end
                holdPending = sTvalid && !rdy;
                holdData = sTdata;
                guard++;
            end
            total++; if (doneCount == 0) begin bad++; $display("[TB] FAIL rand_timeout frame %0d got no done want done", f); end
            total++; if (obsQ.size() != FRAME) begin bad++; $display("[TB] FAIL rand_count got %0d want %0d", obsQ.size(), FRAME); end
            for (int k = 0; k < obsQ.size() && k < FRAME; k++) begin
                total++; if (obsQ[k] !== expBeat(k)) begin bad++; $display("[TB] FAIL rand_beat%0d got %h want %h", k, obsQ[k], expBeat(k)); end
            end
            total++; if (doneCount != 1 || doneBeat != FRAME) begin bad++; $display("[TB] FAIL rand_done got count=%0d beat=%0d want 1/%0d", doneCount, doneBeat, FRAME); end
        end
    endtask

    initial begin
        new_frame();
        test_reset();
        test_full_rate();
        test_unit_stall();
        test_tready_toggle();
        test_restart_ignored();
        test_reset_abort();
        test_flush_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
